// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit hex 7-segment scanner.
package seg7_pkg;

    // Scan sequence: lit digit, blank gap, lit digit, blank gap.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        BLK0 = 2'd1,
        DIG1 = 2'd2,
        BLK1 = 2'd3
    } seg7_state_e;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Cycles each digit stays lit; floored at 4 so the FSM always has room to run.
    function automatic int unsigned seg7_dwell(input int unsigned clk_freq,
                                               input int unsigned refresh_hz);
        int unsigned d;
        d = clk_freq / refresh_hz;
        return (d < 32'd4) ? 32'd4 : d;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment decoder (active-high segments).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_hex_scanner.sv
// Two-digit multiplexed hex display driver with inter-digit blanking and
// tear-free frame-boundary updates.
// Optional build macro LEADING_ZERO_BLANK_EN: keeps the left digit dark when
// the high nibble is zero (DIG1 timing unchanged).
module seg7_hex_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 25_000_000,
    parameter int unsigned REFRESH_HZ   = 1_000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value_i,
    input  logic       value_valid_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [1:0] an_o
);

    localparam int unsigned DWELL = seg7_dwell(CLK_FREQ, REFRESH_HZ);
    // BLANK_CYCLES is below DWELL, so DWELL sets the counter width.
    localparam int          CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);

    // Pin-level "off" patterns; polarity is folded into the output registers.
    localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};
    localparam logic       DP_INV  = ACTIVE_LOW;
    localparam logic [1:0] AN_INV  = {2{ACTIVE_LOW}};

    seg7_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       pending_q;
    logic [7:0]       shadow_q;
    logic             upd_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [1:0]       an_q;

    logic [6:0] seg_lo, seg_hi;
    logic       last;
    logic [7:0] shadow_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic [1:0] an_d;

    seg7_hex_decode u_dec_lo (.nib_i(shadow_q[3:0]), .seg_o(seg_lo));
    seg7_hex_decode u_dec_hi (.nib_i(shadow_q[7:4]), .seg_o(seg_hi));

    // Next-state helpers and the logical display pattern for the current state.
    // Outputs are registered from the current state, so every state is visible
    // for exactly its own length, one cycle behind the FSM.
    always_comb begin
        last     = ((state_q == DIG0) || (state_q == DIG1)) ? (cnt_q == DIG_LAST)
                                                            : (cnt_q == BLK_LAST);
        // A strobe on the boundary edge bypasses pending straight into shadow.
        shadow_d = value_valid_i ? value_i : pending_q;
        seg_d    = '0;
        dp_d     = 1'b0;
        an_d     = '0;
        case (state_q)
            DIG0: begin
                an_d  = 2'b01;
                seg_d = seg_lo;
                dp_d  = upd_q;
            end
            DIG1: begin
                an_d  = 2'b10;
                seg_d = seg_hi;
`ifdef LEADING_ZERO_BLANK_EN
                if (shadow_q[7:4] == 4'h0) begin
                    an_d  = 2'b00;
                    seg_d = '0;
                end
`endif
            end
            default: ;
        endcase
    end

    // Scan FSM, value capture/shadowing and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIG0;
            cnt_q     <= '0;
            pending_q <= 8'h00;
            shadow_q  <= 8'h00;
            upd_q     <= 1'b0;
            seg_q     <= SEG_INV;
            dp_q      <= DP_INV;
            an_q      <= AN_INV;
        end else begin
            if (value_valid_i)
                pending_q <= value_i;

            seg_q <= seg_d ^ SEG_INV;
            dp_q  <= dp_d ^ DP_INV;
            an_q  <= an_d ^ AN_INV;

            if (last) begin
                cnt_q <= '0;
                case (state_q)
                    DIG0: state_q <= BLK0;
                    BLK0: state_q <= DIG1;
                    DIG1: state_q <= BLK1;
                    default: begin
                        // Frame boundary: the only place shadow may change.
                        state_q  <= DIG0;
                        shadow_q <= shadow_d;
                        upd_q    <= (shadow_d != shadow_q);
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_q;
    assign an_o  = an_q;

endmodule
